// File: rtl/rand_range_sampler.sv
// Rejection sampler: masks a random byte to the next power-of-two range and keeps
// candidates below N, queueing accepted samples in a small registered-head FIFO.
module rand_range_sampler #(
    parameter int unsigned P_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ru,
    input  logic [7:0]  range,
    input  logic        range_wr,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] rej_cnt
);

    localparam int unsigned AW = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, CFG, RUN} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [7:0]      n_q;
    logic [7:0]      mask_q;
    logic [7:0]      mem_q [P_FIFO_DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [CW-1:0]   count_q;

    logic            cfg_en_c;
    logic            run_en_c;
    logic [7:0]      nm1_c;
    logic [7:0]      smear1_c;
    logic [7:0]      smear2_c;
    logic [7:0]      mask_c;
    logic [7:0]      cand_c;
    logic            accept_c;
    logic            full_c;
    logic            pop_c;
    logic            push_c;
    logic            reject_c;
    logic [CW-1:0]   count_next_c;
    logic [AW-1:0]   rptr_next_c;
    logic [7:0]      head_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: a range write restarts configuration from any state
    always_comb begin
        state_d = state_q;
        if (range_wr) begin
            state_d = CFG;
        end else begin
            case (state_q)
                CFG:     state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // State-decoded enables; a pending flush suppresses both
    always_comb begin
        cfg_en_c = 1'b0;
        run_en_c = 1'b0;
        if (!range_wr) begin
            cfg_en_c = (state_q == CFG);
            run_en_c = (state_q == RUN);
        end
    end

    // Mask = N-1 with all lower bits filled; N=0 encodes 256 so N-1 wraps to 0xFF
    always_comb begin
        nm1_c    = n_q - 8'd1;
        smear1_c = nm1_c | (nm1_c >> 1);
        smear2_c = smear1_c | (smear1_c >> 2);
        mask_c   = smear2_c | (smear2_c >> 4);
    end

    always_comb begin
        cand_c       = ru & mask_q;
        accept_c     = (n_q == 8'd0) || (cand_c < n_q);
        full_c       = (count_q == CW'(P_FIFO_DEPTH));
        pop_c        = out_valid && out_ready;
        push_c       = run_en_c && accept_c && (!full_c || pop_c);
        reject_c     = run_en_c && !accept_c;
        count_next_c = count_q + CW'(push_c) - CW'(pop_c);
        rptr_next_c  = rptr_q + AW'(pop_c);
        // Next head: bypass the fresh candidate when nothing older survives the pop
        if (count_next_c == '0)             head_c = 8'h00;
        else if (count_q == CW'(pop_c))     head_c = cand_c;
        else                                head_c = mem_q[rptr_next_c];
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wptr_q] <= cand_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q       <= 8'h00;
            mask_q    <= 8'h00;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            rej_cnt   <= 16'h0000;
        end else if (range_wr) begin
            n_q       <= range;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            rej_cnt   <= 16'h0000;
        end else begin
            if (cfg_en_c) mask_q <= mask_c;
            if (push_c)   wptr_q <= wptr_q + AW'(1);
            rptr_q    <= rptr_next_c;
            count_q   <= count_next_c;
            out_valid <= (count_next_c != '0);
            out_data  <= head_c;
            if (reject_c && (rej_cnt != 16'hFFFF)) rej_cnt <= rej_cnt + 16'd1;
        end
    end

endmodule
